// File: rtl/axil_reg_bridge_if.sv
// Bus bundle for axil_reg_bridge: AXI4-Lite slave channels plus the simple
// register-bus strobes toward the timer register block.
interface axil_reg_bridge_if #(
  parameter int AW = 4,
  parameter int DW = 32
);
  logic [AW-1:0]   s_awaddr;
  logic            s_awvalid;
  logic            s_awready;
  logic [DW-1:0]   s_wdata;
  logic [DW/8-1:0] s_wstrb;
  logic            s_wvalid;
  logic            s_wready;
  logic [1:0]      s_bresp;
  logic            s_bvalid;
  logic            s_bready;
  logic [AW-1:0]   s_araddr;
  logic            s_arvalid;
  logic            s_arready;
  logic [DW-1:0]   s_rdata;
  logic [1:0]      s_rresp;
  logic            s_rvalid;
  logic            s_rready;
  logic [AW-1:0]   reg_wr_addr;
  logic [DW-1:0]   reg_wr_data;
  logic            reg_wr_en;
  logic            reg_wr_ready;
  logic [AW-1:0]   reg_rd_addr;
  logic            reg_rd_en;
  logic [DW-1:0]   reg_rd_data;
  logic            reg_rd_valid;

  // Bridge side: AXI slave, register-bus initiator.
  modport slave (
    input  s_awaddr, s_awvalid, s_wdata, s_wstrb, s_wvalid, s_bready,
           s_araddr, s_arvalid, s_rready, reg_wr_ready, reg_rd_data, reg_rd_valid,
    output s_awready, s_wready, s_bresp, s_bvalid, s_arready, s_rdata, s_rresp,
           s_rvalid, reg_wr_addr, reg_wr_data, reg_wr_en, reg_rd_addr, reg_rd_en
  );

  // Environment side: AXI master plus the register block.
  modport master (
    output s_awaddr, s_awvalid, s_wdata, s_wstrb, s_wvalid, s_bready,
           s_araddr, s_arvalid, s_rready, reg_wr_ready, reg_rd_data, reg_rd_valid,
    input  s_awready, s_wready, s_bresp, s_bvalid, s_arready, s_rdata, s_rresp,
           s_rvalid, reg_wr_addr, reg_wr_data, reg_wr_en, reg_rd_addr, reg_rd_en
  );
endinterface

// File: rtl/axil_reg_bridge.sv
// AXI4-Lite slave to register-bus bridge. Independent write and read engines,
// each with its own bus-timeout counter; one outstanding transaction per channel.
module axil_reg_bridge #(
  parameter int AW      = 4,
  parameter int DW      = 32,
  parameter int TIMEOUT = 16
) (
  input logic              clk,
  input logic              rstn,
  axil_reg_bridge_if.slave bus
);

  localparam int              SW          = DW / 8;
  localparam int              CW          = $clog2(TIMEOUT);
  localparam logic [CW-1:0]   CNT_LAST    = CW'(TIMEOUT - 1);
  localparam logic [1:0]      RESP_OKAY   = 2'b00;
  localparam logic [1:0]      RESP_SLVERR = 2'b10;

  typedef enum logic [1:0] {W_IDLE, W_REG, W_RESP} wr_state_t;
  typedef enum logic [1:0] {R_IDLE, R_REG, R_RESP} rd_state_t;

  wr_state_t       wr_state;
  logic            aw_held, w_held;
  logic [AW-1:0]   aw_addr_q;
  logic [DW-1:0]   w_data_q;
  logic [SW-1:0]   w_strb_q;
  logic [CW-1:0]   wr_cnt;

  rd_state_t       rd_state;
  logic [CW-1:0]   rd_cnt;

  logic            aw_hs, w_hs, aw_have, w_have, ar_hs;
  logic [AW-1:0]   wr_addr_sel;
  logic [DW-1:0]   wr_data_sel;
  logic [SW-1:0]   wr_strb_sel;
  logic            wr_bad;

  // Handshake detection; a beat arriving this cycle counts as held so the
  // engine can leave idle on the same edge that completes the AW/W pair.
  always_comb begin
    aw_hs       = bus.s_awready & bus.s_awvalid;
    w_hs        = bus.s_wready & bus.s_wvalid;
    ar_hs       = bus.s_arready & bus.s_arvalid;
    aw_have     = aw_held | aw_hs;
    w_have      = w_held | w_hs;
    wr_addr_sel = aw_held ? aw_addr_q : bus.s_awaddr;
    wr_data_sel = w_held ? w_data_q : bus.s_wdata;
    wr_strb_sel = w_held ? w_strb_q : bus.s_wstrb;
    wr_bad      = (wr_addr_sel[1:0] != 2'b00) || (wr_strb_sel != '1);
  end

  // Write engine: collect AW and W, strobe the register bus, return B.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      wr_state        <= W_IDLE;
      aw_held         <= 1'b0;
      w_held          <= 1'b0;
      aw_addr_q       <= '0;
      w_data_q        <= '0;
      w_strb_q        <= '0;
      wr_cnt          <= '0;
      bus.s_awready   <= 1'b0;
      bus.s_wready    <= 1'b0;
      bus.s_bvalid    <= 1'b0;
      bus.s_bresp     <= '0;
      bus.reg_wr_en   <= 1'b0;
      bus.reg_wr_addr <= '0;
      bus.reg_wr_data <= '0;
    end else begin
      case (wr_state)
        W_IDLE: begin
          if (aw_hs) begin
            aw_addr_q <= bus.s_awaddr;
            aw_held   <= 1'b1;
          end
          if (w_hs) begin
            w_data_q <= bus.s_wdata;
            w_strb_q <= bus.s_wstrb;
            w_held   <= 1'b1;
          end
          bus.s_awready <= !aw_have;
          bus.s_wready  <= !w_have;
          if (aw_have && w_have) begin
            aw_held <= 1'b0;
            w_held  <= 1'b0;
            if (wr_bad) begin
              bus.s_bvalid <= 1'b1;
              bus.s_bresp  <= RESP_SLVERR;
              wr_state     <= W_RESP;
            end else begin
              bus.reg_wr_en   <= 1'b1;
              bus.reg_wr_addr <= wr_addr_sel;
              bus.reg_wr_data <= wr_data_sel;
              wr_cnt          <= '0;
              wr_state        <= W_REG;
            end
          end
        end
        W_REG: begin
          if (bus.reg_wr_ready) begin
            bus.reg_wr_en <= 1'b0;
            bus.s_bvalid  <= 1'b1;
            bus.s_bresp   <= RESP_OKAY;
            wr_state      <= W_RESP;
          end else if (wr_cnt == CNT_LAST) begin
            bus.reg_wr_en <= 1'b0;
            bus.s_bvalid  <= 1'b1;
            bus.s_bresp   <= RESP_SLVERR;
            wr_state      <= W_RESP;
          end else begin
            wr_cnt <= wr_cnt + CW'(1);
          end
        end
        W_RESP: begin
          if (bus.s_bready) begin
            bus.s_bvalid  <= 1'b0;
            bus.s_bresp   <= RESP_OKAY;
            bus.s_awready <= 1'b1;
            bus.s_wready  <= 1'b1;
            wr_state      <= W_IDLE;
          end
        end
        default: wr_state <= W_IDLE;
      endcase
    end
  end

  // Read engine: accept AR, hold the register read request, return R.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      rd_state        <= R_IDLE;
      rd_cnt          <= '0;
      bus.s_arready   <= 1'b0;
      bus.s_rvalid    <= 1'b0;
      bus.s_rdata     <= '0;
      bus.s_rresp     <= '0;
      bus.reg_rd_en   <= 1'b0;
      bus.reg_rd_addr <= '0;
    end else begin
      case (rd_state)
        R_IDLE: begin
          if (ar_hs) begin
            bus.s_arready <= 1'b0;
            if (bus.s_araddr[1:0] != 2'b00) begin
              bus.s_rdata  <= '0;
              bus.s_rresp  <= RESP_SLVERR;
              bus.s_rvalid <= 1'b1;
              rd_state     <= R_RESP;
            end else begin
              bus.reg_rd_addr <= bus.s_araddr;
              bus.reg_rd_en   <= 1'b1;
              rd_cnt          <= '0;
              rd_state        <= R_REG;
            end
          end else begin
            bus.s_arready <= 1'b1;
          end
        end
        R_REG: begin
          if (bus.reg_rd_valid) begin
            bus.reg_rd_en <= 1'b0;
            bus.s_rdata   <= bus.reg_rd_data;
            bus.s_rresp   <= RESP_OKAY;
            bus.s_rvalid  <= 1'b1;
            rd_state      <= R_RESP;
          end else if (rd_cnt == CNT_LAST) begin
            bus.reg_rd_en <= 1'b0;
            bus.s_rdata   <= DW'(32'hDEAD_BEEF);
            bus.s_rresp   <= RESP_SLVERR;
            bus.s_rvalid  <= 1'b1;
            rd_state      <= R_RESP;
          end else begin
            rd_cnt <= rd_cnt + CW'(1);
          end
        end
        R_RESP: begin
          if (bus.s_rready) begin
            bus.s_rvalid  <= 1'b0;
            bus.s_arready <= 1'b1;
            rd_state      <= R_IDLE;
          end
        end
        default: rd_state <= R_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_axil_reg_bridge.sv
// Directed plus randomized bench for axil_reg_bridge. A behavioural register
// block answers the register bus; a register-array model predicts responses.
module tb_axil_reg_bridge;
  localparam int TO = 16;

  logic clk  = 1'b0;
  logic rstn = 1'b0;
  always #5 clk = ~clk;

  axil_reg_bridge_if #(.AW(4), .DW(32)) bus ();

  axil_reg_bridge #(.AW(4), .DW(32), .TIMEOUT(TO)) dut (
    .clk  (clk),
    .rstn (rstn),
    .bus  (bus.slave)
  );

  int total = 0;
  int bad   = 0;
  int cyc   = 0;

  // Register block: contents, write acceptance and read latency controls.
  logic [31:0] regs [4] = '{32'h1111_0000, 32'h2222_0004, 32'h3333_0008, 32'h4444_000C};
  logic [31:0] model [4];
  logic        wr_ready_tie = 1'b1;
  logic        rd_stall     = 1'b0;
  int          rd_lat       = 0;
  int          rd_wait      = 0;
  logic        rd_valid_w;

  assign rd_valid_w       = bus.reg_rd_en && !rd_stall && (rd_wait >= rd_lat);
  assign bus.reg_rd_valid = rd_valid_w;
  assign bus.reg_rd_data  = rd_valid_w ? regs[bus.reg_rd_addr[3:2]] : 32'h5A5A_5A5A;
  assign bus.reg_wr_ready = wr_ready_tie;

  always @(posedge clk) begin
    cyc <= cyc + 1;
    if (bus.reg_wr_en && bus.reg_wr_ready) regs[bus.reg_wr_addr[3:2]] <= bus.reg_wr_data;
    if (bus.reg_rd_en && !rd_valid_w) rd_wait <= rd_wait + 1;
    else rd_wait <= 0;
  end

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // One AXI write; w_lead>0 presents W that many cycles before AW, <0 the reverse.
  task automatic axi_write(input logic [3:0] a, input logic [31:0] d, input logic [3:0] s,
                           input int w_lead, input int bdelay);
    bit bad_req, to, aw_f, w_f, aw_d, w_d, b_hs, done, stable;
    int awstart, wstart, hs, en_first, b_first, en_n, b_n, exp_n;
    logic [1:0] exp_resp, b_seen;
    logic [3:0] en_addr;
    logic [31:0] en_data;
    aw_f = 0; w_f = 0; aw_d = 0; w_d = 0; b_hs = 0; done = 0; stable = 1;
    hs = -1; en_first = -1; b_first = -1; en_n = 0; b_n = 0;
    b_seen = '0; en_addr = '0; en_data = '0;
    bad_req  = (a[1:0] != 2'b00) || (s != 4'hF);
    to       = !bad_req && !wr_ready_tie;
    exp_resp = (bad_req || to) ? 2'b10 : 2'b00;
    if (!bad_req && !to) model[a[3:2]] = d;
    awstart = (w_lead > 0) ? w_lead : 0;
    wstart  = (w_lead < 0) ? -w_lead : 0;
    for (int c = 0; c < 100 && !done; c++) begin
      @(negedge clk);
      if (b_hs) begin
        chk("b_cleared", bus.s_bvalid, 0);
        chk("awready_back", bus.s_awready, 1);
        chk("wready_back", bus.s_wready, 1);
        bus.s_bready = 1'b0;
        done = 1;
      end else begin
        if (bus.reg_wr_en) begin
          en_n++;
          if (en_first < 0) begin
            en_first = cyc; en_addr = bus.reg_wr_addr; en_data = bus.reg_wr_data;
          end
        end
        if (aw_f) begin bus.s_awvalid = 1'b0; aw_f = 0; aw_d = 1; end
        if (w_f) begin bus.s_wvalid = 1'b0; w_f = 0; w_d = 1; end
        if (bus.s_bvalid) begin
          b_n++;
          if (b_first < 0) begin b_first = cyc; b_seen = bus.s_bresp; end
          else if (bus.s_bresp !== b_seen) stable = 0;
          if (b_n > bdelay) begin bus.s_bready = 1'b1; b_hs = 1; end
        end
        if (!aw_d && !aw_f && c >= awstart) begin
          bus.s_awvalid = 1'b1; bus.s_awaddr = a;
          if (bus.s_awready) begin aw_f = 1; if (cyc + 1 > hs) hs = cyc + 1; end
        end
        if (!w_d && !w_f && c >= wstart) begin
          bus.s_wvalid = 1'b1; bus.s_wdata = d; bus.s_wstrb = s;
          if (bus.s_wready) begin w_f = 1; if (cyc + 1 > hs) hs = cyc + 1; end
        end
      end
    end
    if (!done) begin
      bus.s_awvalid = 1'b0; bus.s_wvalid = 1'b0; bus.s_bready = 1'b0;
    end
    chk("wr_done", done, 1);
    chk("bresp", b_seen, exp_resp);
    chk("bresp_stable", stable, 1);
    chk("bvalid_cycles", b_n, bdelay + 1);
    exp_n = bad_req ? 0 : (to ? TO : 1);
    chk("wr_en_cycles", en_n, exp_n);
    chk("b_latency", b_first - hs, exp_n);
    if (!bad_req) begin
      chk("wr_en_latency", en_first - hs, 0);
      chk("wr_addr", en_addr, a);
      chk("wr_data", en_data, d);
    end
    chk("reg_contents", regs[a[3:2]], model[a[3:2]]);
  endtask

  // One AXI read; rdelay holds rready low for that many rvalid cycles.
  task automatic axi_read(input logic [3:0] a, input int rdelay);
    bit mis, stall, ar_f, ar_d, r_hs, done, stable;
    int hs, en_first, r_first, en_n, r_n, exp_n;
    logic [31:0] exp_data, r_data;
    logic [1:0] exp_resp, r_resp;
    logic [3:0] en_addr;
    ar_f = 0; ar_d = 0; r_hs = 0; done = 0; stable = 1;
    hs = -1; en_first = -1; r_first = -1; en_n = 0; r_n = 0;
    r_data = '0; r_resp = '0; en_addr = '0;
    mis      = (a[1:0] != 2'b00);
    stall    = !mis && rd_stall;
    exp_data = mis ? 32'h0 : (stall ? 32'hDEAD_BEEF : model[a[3:2]]);
    exp_resp = (mis || stall) ? 2'b10 : 2'b00;
    exp_n    = mis ? 0 : (stall ? TO : rd_lat + 1);
    for (int c = 0; c < 100 && !done; c++) begin
      @(negedge clk);
      if (r_hs) begin
        chk("r_cleared", bus.s_rvalid, 0);
        chk("arready_back", bus.s_arready, 1);
        bus.s_rready = 1'b0;
        done = 1;
      end else begin
        if (bus.reg_rd_en) begin
          en_n++;
          if (en_first < 0) begin en_first = cyc; en_addr = bus.reg_rd_addr; end
        end
        if (ar_f) begin bus.s_arvalid = 1'b0; ar_f = 0; ar_d = 1; end
        if (bus.s_rvalid) begin
          r_n++;
          if (r_first < 0) begin r_first = cyc; r_data = bus.s_rdata; r_resp = bus.s_rresp; end
          else if (bus.s_rdata !== r_data || bus.s_rresp !== r_resp) stable = 0;
          if (r_n > rdelay) begin bus.s_rready = 1'b1; r_hs = 1; end
        end
        if (!ar_d && !ar_f) begin
          bus.s_arvalid = 1'b1; bus.s_araddr = a;
          if (bus.s_arready) begin ar_f = 1; hs = cyc + 1; end
        end
      end
    end
    if (!done) begin bus.s_arvalid = 1'b0; bus.s_rready = 1'b0; end
    chk("rd_done", done, 1);
    chk("rdata", r_data, exp_data);
    chk("rresp", r_resp, exp_resp);
    chk("r_stable", stable, 1);
    chk("rvalid_cycles", r_n, rdelay + 1);
    chk("rd_en_cycles", en_n, exp_n);
    chk("r_latency", r_first - hs, exp_n);
    if (!mis) begin
      chk("rd_en_latency", en_first - hs, 0);
      chk("rd_addr", en_addr, a);
    end
  endtask

  initial begin
    logic [3:0]  ra, rs;
    logic [31:0] rd;
    bit          seen;
    bus.s_awaddr = '0; bus.s_awvalid = 1'b0; bus.s_wdata = '0; bus.s_wstrb = '0;
    bus.s_wvalid = 1'b0; bus.s_bready = 1'b0; bus.s_araddr = '0; bus.s_arvalid = 1'b0;
    bus.s_rready = 1'b0;
    model = '{32'h1111_0000, 32'h2222_0004, 32'h3333_0008, 32'h4444_000C};

    // Reset state, then readies on the first edge after release.
    repeat (3) @(negedge clk);
    chk("rst_readies", {bus.s_awready, bus.s_wready, bus.s_arready}, 3'b000);
    chk("rst_valids", {bus.s_bvalid, bus.s_rvalid, bus.reg_wr_en, bus.reg_rd_en}, 4'b0000);
    chk("rst_data", {bus.s_rdata, bus.reg_wr_data}, 64'h0);
    rstn = 1'b1;
    @(negedge clk);
    chk("post_rst_readies", {bus.s_awready, bus.s_wready, bus.s_arready}, 3'b111);

    // Directed cases.
    axi_write(4'h4, 32'h0000_1234, 4'hF, 0, 0);
    axi_write(4'h0, 32'h0000_0001, 4'hF, 2, 5);
    axi_write(4'hC, 32'h0000_0001, 4'hF, -1, 0);
    axi_read(4'hC, 0);
    axi_read(4'h2, 1);
    rd_stall = 1'b1;
    axi_read(4'h8, 0);
    rd_stall = 1'b0;
    axi_write(4'h8, 32'h0000_FFFF, 4'h3, 0, 0);
    axi_write(4'h5, 32'h0000_ABCD, 4'hF, 1, 0);
    wr_ready_tie = 1'b0;
    axi_write(4'h4, 32'hCAFE_0000, 4'hF, 0, 1);
    wr_ready_tie = 1'b1;
    rd_lat = 3;
    axi_read(4'h4, 2);
    rd_lat = 0;

    // Reset during W_REG (write stalled) and R_RESP (rready low).
    wr_ready_tie = 1'b0;
    @(negedge clk);
    bus.s_awaddr = 4'h4; bus.s_wdata = 32'h7777_7777; bus.s_wstrb = 4'hF;
    bus.s_awvalid = 1'b1; bus.s_wvalid = 1'b1; bus.s_araddr = 4'h0; bus.s_arvalid = 1'b1;
    @(negedge clk);
    bus.s_awvalid = 1'b0; bus.s_wvalid = 1'b0; bus.s_arvalid = 1'b0;
    chk("mid_reg_strobes", {bus.reg_wr_en, bus.reg_rd_en}, 2'b11);
    @(negedge clk);
    chk("mid_rresp_state", {bus.s_rvalid, bus.reg_wr_en}, 2'b11);
    #2 rstn = 1'b0;
    #1;
    chk("async_rst_ctrl", {bus.s_awready, bus.s_wready, bus.s_arready, bus.s_bvalid,
                           bus.s_rvalid, bus.reg_wr_en, bus.reg_rd_en}, 7'b0);
    chk("async_rst_data", {bus.s_rdata, bus.reg_wr_data}, 64'h0);
    chk("async_rst_addr", {bus.reg_wr_addr, bus.reg_rd_addr, bus.s_bresp, bus.s_rresp}, 12'h0);
    repeat (2) @(negedge clk);
    rstn = 1'b1;
    wr_ready_tie = 1'b1;
    @(negedge clk);
    chk("rel_readies", {bus.s_awready, bus.s_wready, bus.s_arready}, 3'b111);
    seen = 0;
    repeat (4) begin
      if (bus.s_bvalid || bus.s_rvalid || bus.reg_wr_en || bus.reg_rd_en) seen = 1;
      @(negedge clk);
    end
    chk("no_stale_response", seen, 0);
    chk("stalled_write_dropped", regs[1], model[1]);

    // Randomized traffic against the register-array model.
    repeat (40) begin
      ra = 4'($urandom_range(0, 15));
      if ($urandom_range(0, 3) != 0) ra[1:0] = 2'b00;
      if ($urandom_range(0, 1) == 0) begin
        rd = $urandom;
        rs = ($urandom_range(0, 4) == 0) ? 4'($urandom_range(0, 15)) : 4'hF;
        wr_ready_tie = ($urandom_range(0, 7) != 0);
        axi_write(ra, rd, rs, int'($urandom_range(0, 4)) - 2, int'($urandom_range(0, 3)));
        wr_ready_tie = 1'b1;
      end else begin
        rd_lat   = int'($urandom_range(0, 3));
        rd_stall = ($urandom_range(0, 7) == 0);
        axi_read(ra, int'($urandom_range(0, 3)));
        rd_stall = 1'b0;
      end
    end
    rd_lat = 0;
    for (int i = 0; i < 4; i++) begin
      ra = 4'(i * 4);
      axi_read(ra, 0);
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
